// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// FETCH_PC_TAG_EN widens the return entry with the fetch PC of each word.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] inst_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STALL
  } fetch_state_t;

  localparam inst_t           NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One return-FIFO entry: instruction word, optionally tagged with its PC.
  typedef struct packed {
`ifdef FETCH_PC_TAG_EN
    logic [XLEN-1:0] pc;
`endif
    inst_t           inst;
  } ret_entry_t;

endpackage

// File: rtl/fetch_return_fifo.sv
// Return FIFO holding memory data while the instruction queue back-pressures.
// Entry width follows ret_entry_t (widened when FETCH_PC_TAG_EN is defined).
module fetch_return_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       wr_en,
  input  ret_entry_t wr_data,
  input  logic       rd_en,
  output ret_entry_t rd_data,
  output logic       not_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ret_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_rd;
  logic             full;

  assign do_rd     = rd_en && (count != '0);
  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign rd_data   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; clear beats write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr_en) - CNT_W'(do_rd);
    end
  end

  // The credit counter upstream must never let a write hit a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && !clr && full));

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues fixed-latency BRAM reads under a credit limit,
// buffers returns and feeds the instruction queue. FETCH_PC_TAG_EN adds pc_out.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int unsigned     MEM_LATENCY  = 2,
  parameter int unsigned     MAX_INFLIGHT = 4
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            enable_in,
  input  logic            redirect_valid_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic [XLEN-1:0] imem_data_in,
  output logic            valid_out,
  output logic [XLEN-1:0] instruction_out,
  input  logic            ready_in
`ifdef FETCH_PC_TAG_EN
  ,
  output logic [XLEN-1:0] pc_out
`endif
);

  localparam int unsigned OCC_W = $clog2(MAX_INFLIGHT) + 1;

  fetch_state_t     state;
  logic [XLEN-1:0]  pc;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic [MEM_LATENCY-1:0] lat_pipe;
  logic             issue;
  logic             pop;
  logic             ret_valid;
  ret_entry_t       ret_entry;
  ret_entry_t       head;
  logic [1:0]       unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc_in[1:0];

  assign issue           = (state == FETCH) && (occ < OCC_W'(MAX_INFLIGHT)) && !redirect_valid_in;
  assign imem_req_out    = issue;
  assign imem_addr_out   = pc;
  assign pop             = valid_out && ready_in;
  assign ret_valid       = lat_pipe[MEM_LATENCY-1];
  assign occ_next        = occ + OCC_W'(issue) - OCC_W'(pop);
  assign instruction_out = head.inst;

  // PC, credits, latency pipe and fetch state; a redirect wipes all wrong-path state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      occ      <= '0;
      lat_pipe <= '0;
    end else begin
      if (redirect_valid_in) begin
        pc       <= {redirect_pc_in[XLEN-1:2], 2'b00};
        occ      <= '0;
        lat_pipe <= '0;
      end else begin
        if (issue) pc <= pc + XLEN'(4);
        occ      <= occ_next;
        lat_pipe <= (lat_pipe << 1) | MEM_LATENCY'(issue);
      end

      if (!enable_in) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    state <= FETCH;
          FETCH:   if (!redirect_valid_in && occ_next == OCC_W'(MAX_INFLIGHT)) state <= STALL;
          STALL:   if (redirect_valid_in || occ_next < OCC_W'(MAX_INFLIGHT)) state <= FETCH;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FETCH_PC_TAG_EN
  logic [XLEN-1:0] pc_pipe [MEM_LATENCY];

  // Request addresses travel alongside the valid bits so each word keeps its PC.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(MEM_LATENCY); i++) pc_pipe[i] <= '0;
    end else begin
      pc_pipe[0] <= pc;
      for (int i = 1; i < int'(MEM_LATENCY); i++) pc_pipe[i] <= pc_pipe[i-1];
    end
  end

  assign pc_out = head.pc;
`endif

  always_comb begin
    ret_entry      = '0;
    ret_entry.inst = imem_data_in;
`ifdef FETCH_PC_TAG_EN
    ret_entry.pc   = pc_pipe[MEM_LATENCY-1];
`endif
  end

  fetch_return_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_ret_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .clr       (redirect_valid_in),
    .wr_en     (ret_valid),
    .wr_data   (ret_entry),
    .rd_en     (pop),
    .rd_data   (head),
    .not_empty (valid_out)
  );

endmodule
